// File: rtl/adder_accum.sv
`default_nettype none
// ============================================================================
// Module      : adder_accum
// Description : Saturating accumulator for a run of 9-bit adder results
//               ({cout,sum}), with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_accum #(
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       sum,
    input  logic             cout,
    output logic [ACC_W-1:0] acc,
    output logic             acc_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ACC_W-1:0] C_ACC_MAX = '1;

    logic [1:0]       r_state;
    logic [4:0]       r_remaining;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_acc_valid;

    logic             w_xfer;
    logic [ACC_W:0]   w_sum;
    logic             w_sat;

    assign w_xfer = (r_state == S_ACCUM) && in_valid;
    // One spare bit catches the carry past ACC_W; once acc is all-ones any
    // non-zero addend carries out again, so saturation is self-sustaining.
    assign w_sum  = {1'b0, r_acc} + {{(ACC_W-8){1'b0}}, cout, sum};
    assign w_sat  = w_sum[ACC_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= 5'd0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_acc_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= (len == 4'd0) ? 5'd16 : {1'b0, len};
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        r_acc       <= w_sat ? C_ACC_MAX : w_sum[ACC_W-1:0];
                        r_remaining <= r_remaining - 5'd1;
                        if (w_sat) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_remaining == 5'd1) begin
                            r_state     <= S_DONE;
                            r_acc_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_acc_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_acc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_ACCUM);
    assign busy      = (r_state == S_ACCUM) || (r_state == S_DONE);
    assign acc       = r_acc;
    assign overflow  = r_ovf;
    assign acc_valid = r_acc_valid;

endmodule
`default_nettype wire

// File: tb/tb_adder_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_accum
// Description : Self-checking bench for adder_accum (vector table, directed
//               corner sequences, randomized runs against a saturating model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_accum;

    localparam int ACC_W = 12;
    localparam int C_MAX = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       len = 4'd0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       sum = 8'd0;
    logic             cout = 1'b0;
    logic [ACC_W-1:0] acc;
    logic             acc_valid;
    logic             out_ready = 1'b0;
    logic             overflow;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    adder_accum #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .acc       (acc),
        .acc_valid (acc_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] l;
        logic [8:0] v;
        int         exp_acc;
        bit         exp_ovf;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input int t);
        return (t > C_MAX) ? C_MAX : t;
    endfunction

    task automatic xfer(input bit iv, input logic [8:0] v);
        in_valid    = iv;
        {cout, sum} = v;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic begin_run(input logic [3:0] l);
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        len   = 4'd0;
    endtask

    task automatic release_done(input string nm, input int exp_acc, input bit exp_ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, " acc_valid cleared"}, int'(acc_valid), 0);
        check({nm, " busy cleared"}, int'(busy), 0);
        check({nm, " acc held in idle"}, int'(acc), exp_acc);
        check({nm, " ovf held in idle"}, int'(overflow), int'(exp_ovf));
    endtask

    // Constant value every sample, in_valid held high; also measures latency
    // with the start cycle counted as cycle 1.
    task automatic run_const(input string nm, input logic [3:0] l, input logic [8:0] v,
                             input int exp_acc, input bit exp_ovf);
        int eff;
        int cyc;
        eff = (l == 4'd0) ? 16 : int'(l);
        begin_run(l);
        cyc         = 2;
        in_valid    = 1'b1;
        {cout, sum} = v;
        while (!acc_valid && cyc < 60) begin
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check({nm, " latency"}, cyc, eff + 2);
        check({nm, " acc"}, int'(acc), exp_acc);
        check({nm, " ovf"}, int'(overflow), int'(exp_ovf));
        release_done(nm, exp_acc, exp_ovf);
    endtask

    task automatic rand_run(input int idx);
        int l;
        int eff;
        int total;
        int k;
        int guard;
        int hold;
        bit iv;
        logic [8:0] v;
        string nm;
        nm    = $sformatf("rand%0d", idx);
        l     = $urandom_range(0, 15);
        eff   = (l == 0) ? 16 : l;
        total = 0;
        k     = 0;
        guard = 0;
        begin_run(4'(l));
        while (k < eff && guard < 200) begin
            check({nm, " in_ready"}, int'(in_ready), 1);
            iv          = 1'($urandom_range(0, 1));
            v           = 9'($urandom_range(0, 511));
            start       = ($urandom_range(0, 3) == 0);
            len         = 4'($urandom_range(0, 15));
            in_valid    = iv;
            {cout, sum} = v;
            tick();
            if (iv) begin
                total += int'(v);
                k++;
            end
            check({nm, " running acc"}, int'(acc), sat(total));
            guard++;
        end
        in_valid = 1'b0;
        check({nm, " acc_valid"}, int'(acc_valid), 1);
        check({nm, " in_ready in done"}, int'(in_ready), 0);
        check({nm, " ovf"}, int'(overflow), int'(total > C_MAX));
        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            start = 1'($urandom_range(0, 1));
            tick();
            check({nm, " held acc"}, int'(acc), sat(total));
            check({nm, " held valid"}, int'(acc_valid), 1);
        end
        start = 1'($urandom_range(0, 1));
        release_done(nm, sat(total), total > C_MAX);
        start = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{l: 4'd1,  v: 9'd0,   exp_acc: 0,     exp_ovf: 1'b0};
        vecs[1] = '{l: 4'd1,  v: 9'd511, exp_acc: 511,   exp_ovf: 1'b0};
        vecs[2] = '{l: 4'd8,  v: 9'd511, exp_acc: 4088,  exp_ovf: 1'b0};
        vecs[3] = '{l: 4'd9,  v: 9'd511, exp_acc: 4095,  exp_ovf: 1'b1};
        vecs[4] = '{l: 4'd15, v: 9'd273, exp_acc: 4095,  exp_ovf: 1'b0};
        vecs[5] = '{l: 4'd0,  v: 9'd255, exp_acc: 4080,  exp_ovf: 1'b0};
        vecs[6] = '{l: 4'd0,  v: 9'd256, exp_acc: 4095,  exp_ovf: 1'b1};
        vecs[7] = '{l: 4'd5,  v: 9'd100, exp_acc: 500,   exp_ovf: 1'b0};

        // Reset, with start asserted to show reset wins.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("reset acc", int'(acc), 0);
        check("reset ovf", int'(overflow), 0);
        check("reset acc_valid", int'(acc_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset in_ready", int'(in_ready), 0);

        for (int i = 0; i < 8; i++) begin
            run_const($sformatf("vec%0d", i), vecs[i].l, vecs[i].v,
                      vecs[i].exp_acc, vecs[i].exp_ovf);
        end

        // Two-sample run: 0x1C + 0x0C, valid four cycles from start.
        begin_run(4'd2);
        check("r2 busy", int'(busy), 1);
        check("r2 ovf cleared on start", int'(overflow), 0);
        xfer(1'b1, 9'h01C);
        check("r2 valid early", int'(acc_valid), 0);
        xfer(1'b1, 9'h00C);
        check("r2 acc_valid cycle4", int'(acc_valid), 1);
        check("r2 acc", int'(acc), 'h028);
        check("r2 ovf", int'(overflow), 0);

        // Backpressure in DONE with stray start pulses.
        for (int i = 0; i < 5; i++) begin
            start = 1'(i % 2);
            tick();
            check("bp acc", int'(acc), 'h028);
            check("bp valid", int'(acc_valid), 1);
            check("bp ovf", int'(overflow), 0);
            check("bp busy", int'(busy), 1);
        end
        start = 1'b0;
        release_done("bp", 'h028, 1'b0);

        // Sixteen max-value samples: saturates on the ninth.
        begin_run(4'd0);
        for (int i = 1; i <= 16; i++) begin
            xfer(1'b1, 9'h1FF);
            if (i == 8) begin
                check("r16 acc@8", int'(acc), 4088);
                check("r16 ovf@8", int'(overflow), 0);
            end
            if (i == 9) begin
                check("r16 acc@9", int'(acc), 'hFFF);
                check("r16 ovf@9", int'(overflow), 1);
            end
            if (i == 15) check("r16 valid@15", int'(acc_valid), 0);
        end
        check("r16 valid", int'(acc_valid), 1);
        check("r16 acc", int'(acc), 'hFFF);
        check("r16 ovf", int'(overflow), 1);
        release_done("r16", 'hFFF, 1'b1);

        // Gapped in_valid: garbage presented on idle beats must not count.
        begin_run(4'd3);
        xfer(1'b1, 9'h010);
        xfer(1'b0, 9'h1FF);
        xfer(1'b1, 9'h020);
        xfer(1'b0, 9'h1FF);
        check("gap not done", int'(acc_valid), 0);
        xfer(1'b1, 9'h030);
        check("gap valid", int'(acc_valid), 1);
        check("gap acc", int'(acc), 'h060);
        release_done("gap", 'h060, 1'b0);

        // Mid-run reset discards the partial run.
        begin_run(4'd4);
        xfer(1'b1, 9'h028);
        xfer(1'b1, 9'h028);
        check("mid acc", int'(acc), 'h050);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("mid rst acc", int'(acc), 0);
        check("mid rst busy", int'(busy), 0);
        check("mid rst in_ready", int'(in_ready), 0);
        begin_run(4'd1);
        xfer(1'b1, 9'h007);
        check("fresh valid", int'(acc_valid), 1);
        check("fresh acc", int'(acc), 'h007);
        check("fresh ovf", int'(overflow), 0);
        release_done("fresh", 'h007, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rand_run(i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
